// File: rtl/game_pkg.sv
// Shared definitions for the flappy-bird control FSM and its datapath:
// state codes, frame timing default and colour constants.
package game_pkg;

  localparam int unsigned FRAME_CYCLES_DEFAULT = 833333;

  localparam logic [3:0] ST_DRAW_BIRD      = 4'd0;
  localparam logic [3:0] ST_DRAW_WALL_TOP  = 4'd1;
  localparam logic [3:0] ST_DRAW_WALL_BOT  = 4'd2;
  localparam logic [3:0] ST_ERASE_BIRD     = 4'd3;
  localparam logic [3:0] ST_ERASE_WALL_TOP = 4'd4;
  localparam logic [3:0] ST_ERASE_WALL_BOT = 4'd5;
  localparam logic [3:0] ST_WAIT_FRAME     = 4'd6;
  localparam logic [3:0] ST_UPDATE         = 4'd7;
  localparam logic [3:0] ST_CHECK          = 4'd8;
  localparam logic [3:0] ST_GAME_OVER      = 4'd9;
  localparam logic [3:0] ST_IDLE           = 4'd10;

  typedef enum logic [3:0] {
    DRAW_BIRD      = ST_DRAW_BIRD,
    DRAW_WALL_TOP  = ST_DRAW_WALL_TOP,
    DRAW_WALL_BOT  = ST_DRAW_WALL_BOT,
    ERASE_BIRD     = ST_ERASE_BIRD,
    ERASE_WALL_TOP = ST_ERASE_WALL_TOP,
    ERASE_WALL_BOT = ST_ERASE_WALL_BOT,
    WAIT_FRAME     = ST_WAIT_FRAME,
    UPDATE         = ST_UPDATE,
    CHECK          = ST_CHECK,
    GAME_OVER      = ST_GAME_OVER,
    IDLE           = ST_IDLE
  } state_t;

  // 3-bit RGB colours used by the datapath for each drawn object.
  localparam logic [2:0] COLOUR_BG   = 3'b000;
  localparam logic [2:0] COLOUR_BIRD = 3'b110;
  localparam logic [2:0] COLOUR_WALL = 3'b010;

  // True while a game is running (flap presses and wall passes count).
  function automatic logic in_play(input state_t s);
    return (s != IDLE) && (s != GAME_OVER);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Free-running frame counter; tick is high on the wrap cycle.
module frame_timer
  import game_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int unsigned CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn)            count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + 1'b1;
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/game_control.sv
// Top-level sequencing FSM: draws/erases/updates bird and wall once per
// frame, latches flap presses, keeps score and handles game over.
module game_control
  import game_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEFAULT,
  parameter int unsigned SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               go,
  input  logic               finished_draw,
  input  logic               collision,
  input  logic               wall_wrap,
  output logic [3:0]         cur_state,
  output logic               update_en,
  output logic               flap,
  output logic               restart,
  output logic               game_over,
  output logic [SCORE_W-1:0] score_out
);

  state_t state, state_next;
  logic   go_q, go_rise, tick;
  logic   frame_pending, flap_req, flap_req_next;
  logic   start, wait_exit;

  frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_frame_timer (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick)
  );

  assign go_rise   = go & ~go_q;
  assign start     = (state == IDLE) && go_rise;
  assign wait_exit = (state == WAIT_FRAME) && frame_pending;
  assign cur_state = state;

  // NOTE: every signal driven here gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      DRAW_BIRD:      if (finished_draw) state_next = DRAW_WALL_TOP;
      DRAW_WALL_TOP:  if (finished_draw) state_next = DRAW_WALL_BOT;
      DRAW_WALL_BOT:  if (finished_draw) state_next = WAIT_FRAME;
      ERASE_BIRD:     if (finished_draw) state_next = ERASE_WALL_TOP;
      ERASE_WALL_TOP: if (finished_draw) state_next = ERASE_WALL_BOT;
      ERASE_WALL_BOT: if (finished_draw) state_next = UPDATE;
      WAIT_FRAME:     if (frame_pending) state_next = ERASE_BIRD;
      UPDATE:         state_next = CHECK;
      CHECK:          state_next = collision ? GAME_OVER : DRAW_BIRD;
      GAME_OVER:      if (go_rise) state_next = IDLE;
      IDLE:           if (go_rise) state_next = DRAW_BIRD;
      default:        state_next = IDLE;
    endcase
  end

  // A press during UPDATE is consumed by the next frame, not this one.
  always_comb begin
    flap_req_next = flap_req;
    if (state == UPDATE)               flap_req_next = go_rise;
    else if (start)                    flap_req_next = 1'b0;
    else if (go_rise && in_play(state)) flap_req_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      go_q          <= 1'b0;
      frame_pending <= 1'b0;
      flap_req      <= 1'b0;
      update_en     <= 1'b0;
      flap          <= 1'b0;
      restart       <= 1'b0;
      game_over     <= 1'b0;
      score_out     <= '0;
    end else begin
      go_q     <= go;
      flap_req <= flap_req_next;
      // Ticks arriving while a frame is still pending are dropped.
      if (wait_exit) frame_pending <= 1'b0;
      else if (tick) frame_pending <= 1'b1;
      update_en <= (state_next == UPDATE);
      flap      <= (state_next == UPDATE) && flap_req_next;
      restart   <= start;
      game_over <= (state_next == GAME_OVER);
      if (start)
        score_out <= '0;
      else if (wall_wrap && in_play(state) && (score_out != '1))
        score_out <= score_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_game_control.sv
// Self-checking bench for game_control: directed phases plus random traffic,
// compared every cycle against a frame-level behavioural model.
module tb_game_control;

  localparam int FC = 16;

  logic       clk = 1'b0;
  logic       resetn, go, finished_draw, collision, wall_wrap;
  logic [3:0] cur_state, cur_state_s;
  logic       update_en, flap, restart, game_over;
  logic       update_en_s, flap_s, restart_s, game_over_s;
  logic [7:0] score_out;
  logic [1:0] score_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  game_control #(.FRAME_CYCLES(FC), .SCORE_W(8)) dut (
    .clk(clk), .resetn(resetn), .go(go), .finished_draw(finished_draw),
    .collision(collision), .wall_wrap(wall_wrap), .cur_state(cur_state),
    .update_en(update_en), .flap(flap), .restart(restart),
    .game_over(game_over), .score_out(score_out)
  );

  game_control #(.FRAME_CYCLES(FC), .SCORE_W(2)) dut_sat (
    .clk(clk), .resetn(resetn), .go(go), .finished_draw(finished_draw),
    .collision(collision), .wall_wrap(wall_wrap), .cur_state(cur_state_s),
    .update_en(update_en_s), .flap(flap_s), .restart(restart_s),
    .game_over(game_over_s), .score_out(score_s)
  );

  // Model: a game is idle, over, drawing (step 0..5 of the frame's six
  // rectangles), waiting for the frame, updating, or checking.
  typedef enum {M_IDLE, M_OVER, M_DRAW, M_WAIT, M_UPD, M_CHK} mode_t;

  mode_t m_mode;
  int    m_idx, m_cnt, m_score, m_score_s;
  bit    m_pending, m_flap_req, m_go_q;
  bit    e_upd, e_flap, e_restart, e_over;

  function automatic int code_of(input mode_t m, input int idx);
    case (m)
      M_DRAW:  return idx;
      M_WAIT:  return 6;
      M_UPD:   return 7;
      M_CHK:   return 8;
      M_OVER:  return 9;
      default: return 10;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit g, input bit fd,
                            input bit c, input bit ww);
    bit rise, tick, play, start;
    mode_t old;
    if (!rst) begin
      m_mode = M_IDLE; m_idx = 0; m_cnt = 0; m_pending = 0; m_flap_req = 0;
      m_go_q = 0; m_score = 0; m_score_s = 0;
      e_upd = 0; e_flap = 0; e_restart = 0; e_over = 0;
      return;
    end
    rise  = g && !m_go_q;
    tick  = (m_cnt == FC - 1);
    play  = (m_mode != M_IDLE) && (m_mode != M_OVER);
    start = (m_mode == M_IDLE) && rise;
    old   = m_mode;
    m_go_q = g;
    m_cnt  = tick ? 0 : m_cnt + 1;
    case (m_mode)
      M_DRAW: if (fd) begin
        if (m_idx == 2)      m_mode = M_WAIT;
        else if (m_idx == 5) m_mode = M_UPD;
        else                 m_idx++;
      end
      M_WAIT: if (m_pending) begin m_mode = M_DRAW; m_idx = 3; end
      M_UPD:  m_mode = M_CHK;
      M_CHK:  if (c) m_mode = M_OVER; else begin m_mode = M_DRAW; m_idx = 0; end
      M_OVER: if (rise) m_mode = M_IDLE;
      default: if (rise) begin m_mode = M_DRAW; m_idx = 0; end
    endcase
    if (old == M_WAIT && m_pending) m_pending = 0;
    else if (tick)                  m_pending = 1;
    if (old == M_UPD)     m_flap_req = rise;
    else if (start)       m_flap_req = 0;
    else if (rise && play) m_flap_req = 1;
    if (start) begin
      m_score = 0; m_score_s = 0;
    end else if (ww && play) begin
      if (m_score < 255) m_score++;
      if (m_score_s < 3) m_score_s++;
    end
    e_upd     = (m_mode == M_UPD);
    e_flap    = e_upd && m_flap_req;
    e_restart = start;
    e_over    = (m_mode == M_OVER);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
  endtask

  task automatic step(input bit rst, input bit g, input bit fd,
                      input bit c, input bit ww);
    resetn = rst; go = g; finished_draw = fd; collision = c; wall_wrap = ww;
    model_step(rst, g, fd, c, ww);
    @(posedge clk); #1;
    check("cur_state", cur_state, code_of(m_mode, m_idx));
    check("update_en", update_en, e_upd);
    check("flap",      flap,      e_flap);
    check("restart",   restart,   e_restart);
    check("game_over", game_over, e_over);
    check("score_out", score_out, m_score);
    check("sat_score", score_s,   m_score_s);
    check("sat_state", cur_state_s, code_of(m_mode, m_idx));
  endtask

  initial begin
    bit reached;
    m_mode = M_IDLE;
    repeat (2) step(0, 0, 0, 0, 0);
    check("reset_state", cur_state, 10);
    repeat (100) step(1, 0, 0, 0, 0);

    // Start a game, draw every 5 cycles, three presses in the first frame.
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 120; i++)
      step(1, (i == 7 || i == 11 || i == 15), (i % 5 == 4), 0,
           (i == 30 || i == 50 || i == 70));
    for (int i = 0; i < 60; i++) step(1, 0, (i % 5 == 4), 0, 0);

    // Slow draw spans several frame ticks; spurious strobes land in WAIT.
    for (int i = 0; i < 200; i++) step(1, 0, (i % 40 == 39), 0, 0);
    for (int i = 0; i < 60; i++) step(1, 0, (i % 2 == 0), 0, 0);

    // Collision ends the game; wall passes during game over are ignored.
    for (int i = 0; i < 60; i++) step(1, 0, (i % 3 == 2), 1, (i % 7 == 0));
    check("over_reached", game_over, 1);
    step(1, 1, 0, 0, 1); step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
    check("restart_score", score_out, 0);

    // Many wall passes to drive the narrow score into saturation.
    for (int i = 0; i < 80; i++) step(1, 0, (i % 4 == 3), 0, (i % 6 == 0));

    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 499) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 7) == 0);

    // Drive into ERASE_WALL_TOP, then reset in the middle of that draw.
    reached = 0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      if (m_mode == M_DRAW && m_idx == 4) reached = 1;
      else if (m_mode == M_IDLE || m_mode == M_OVER) step(1, i % 2, 0, 0, 0);
      else step(1, 0, $urandom_range(0, 2) == 0, 0, 0);
    end
    check("reach_erase_top", reached, 1);
    step(0, 0, 1, 0, 0);
    check("reset_mid_erase", cur_state, 10);
    step(1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_control.md
Name: game_control

Overview:
- Top-level sequencing FSM for the flappy-bird game, directly upstream of the datapath.
- Drives the datapath's cur_state code so that it draws, erases and updates the bird and the wall once per video frame.
- Consumes the datapath's finished_draw and collision outputs.
- Owns the frame timer, the flap-request latch, the score counter and game-over handling.

Parameters:
- FRAME_CYCLES, 833333: clk cycles per frame tick (50 MHz / 60 Hz).
- SCORE_W, 8: score counter width.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  synchronous, active-low reset
- go  in  1  flap/start button, level, active-high, already synchronised
- finished_draw  in  1  datapath rectangle-draw completion strobe
- collision  in  1  datapath bird/wall overlap flag, level
- wall_wrap  in  1  1-cycle pulse from the wall datapath when the wall re-enters at the right edge
- cur_state  out  4  state code to the datapath
- update_en  out  1  1-cycle pulse: advance bird and wall positions
- flap  out  1  1-cycle pulse coincident with update_en: apply an upward impulse to the bird
- restart  out  1  1-cycle pulse: reinitialise bird, wall and random generator
- game_over  out  1  high while in GAME_OVER
- score_out  out  SCORE_W  walls passed in the current game

Behaviour:
- Reset (resetn=0 sampled at a clk edge) gives:
  - state=IDLE, frame counter=0, frame_pending=0, flap_req=0, go_q=0, score=0.
  - All pulse outputs 0, game_over=0.
  - Reset mid-draw abandons the draw immediately.
- go edge detect: go_rise = go & ~go_q, with go_q registered every cycle.
- Frame timer:
  - Free-running 0..FRAME_CYCLES-1; tick on the wrap cycle.
  - The tick sets frame_pending. frame_pending clears when WAIT_FRAME exits.
  - A tick while frame_pending is already set is dropped (no accumulation).
- State encoding (4-bit) and transitions; all registered, one transition per clk:
  - DRAW_BIRD=0 -> DRAW_WALL_TOP on finished_draw.
  - DRAW_WALL_TOP=1 -> DRAW_WALL_BOT on finished_draw.
  - DRAW_WALL_BOT=2 -> WAIT_FRAME on finished_draw.
  - ERASE_BIRD=3 -> ERASE_WALL_TOP=4 -> ERASE_WALL_BOT=5 -> UPDATE, each step on finished_draw. The datapath draws these in background colour.
  - WAIT_FRAME=6 -> ERASE_BIRD when frame_pending=1.
  - UPDATE=7: exactly one cycle. update_en=1, flap=flap_req, flap_req cleared -> CHECK.
  - CHECK=8: exactly one cycle. collision=1 -> GAME_OVER, else -> DRAW_BIRD.
  - GAME_OVER=9: game_over=1. go_rise -> IDLE.
  - IDLE=10: go_rise -> DRAW_BIRD, with restart=1 and score cleared in that same cycle.
  - Codes 11-15 are illegal and recover to IDLE on the next clk.
- finished_draw is honoured only in states 0-5 and ignored elsewhere.
- flap_req:
  - Set by go_rise in any state except IDLE and GAME_OVER.
  - Multiple presses within one frame collapse to one flap.
  - go_rise in the UPDATE cycle itself sets flap_req for the next frame; the clear takes priority over the set for the current value only.
- Score:
  - Increments on wall_wrap, but only when the state is not IDLE or GAME_OVER.
  - Saturates at 2^SCORE_W-1.
  - Holds its value through GAME_OVER so it can be displayed.
- Latency: update_en occurs 3 finished_draw strobes plus 1 cycle after the WAIT_FRAME exit.
- Outputs are registered, not decoded combinationally from next-state.

Decomposition:
- Shared package game_pkg holds:
  - the 4-bit state localparams above, also used by the datapath;
  - FRAME_CYCLES default;
  - colour constants.
- One sub-module, frame_timer (counter plus tick output), parameterised by FRAME_CYCLES, so the bench can shorten it.

Test Plan:
- Reset then idle: FRAME_CYCLES=16, resetn low 2 cycles -> cur_state=10, score_out=0, all pulses 0. Hold IDLE with no go for 100 cycles -> no change.
- Start and draw sequence: go_rise, then finished_draw pulses every 5 cycles -> restart=1 for 1 cycle. cur_state steps 0,1,2,6, then on the tick 3,4,5,7,8,0. update_en=1 exactly once per frame.
- Flap latch: 3 go_rise pulses inside one frame -> one flap=1 pulse, aligned with update_en. No press in the next frame -> flap=0 at its update.
- Collision: collision=1 during CHECK -> cur_state=9, game_over=1, score frozen. go_rise -> IDLE. go_rise -> restart and score_out=0.
- Score: 3 wall_wrap pulses mid-game -> score_out=3. wall_wrap during GAME_OVER -> no change. SCORE_W=2 with 5 pulses -> saturates at 3.
- Disturbances and reset:
  - Slow draw: finished_draw delayed past 2 frame ticks -> only one pending frame; next WAIT_FRAME exits immediately once.
  - Spurious finished_draw in WAIT_FRAME -> ignored.
  - resetn low mid-ERASE_WALL_TOP -> state 10 next cycle.
